// File: rtl/sparse_loc_scheduler.sv
// Sequencer for the sparse-dense multiplier: walks the real locations in RAM order and
// optionally pads each run to MAX_WEIGHT ops with LFSR-placed dummies for constant timing.
module sparse_loc_scheduler #(
    parameter int MAX_WEIGHT     = 75,
    parameter int N              = 17669,
    parameter int M              = 15,
    parameter int LOG_MAX_WEIGHT = 7,
    parameter int LFSR_WIDTH     = 16,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [LOG_MAX_WEIGHT-1:0] weight,
    input  logic                      dummy_en,
    input  logic                      seed_load,
    input  logic [LFSR_WIDTH-1:0]     seed_in,
    output logic [LOG_MAX_WEIGHT-1:0] loc_addr,
    input  logic [M-1:0]              loc_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [M-1:0]              out_loc,
    output logic                      out_dummy,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);
    // Galois taps for x^16+x^14+x^13+x^11+1 (right-shifting form)
    localparam logic [LFSR_WIDTH-1:0]     TAPS   = LFSR_WIDTH'(16'hB400);
    localparam logic [M-1:0]              N_M    = M'(N);
    localparam logic [LOG_MAX_WEIGHT-1:0] MAXW   = LOG_MAX_WEIGHT'(MAX_WEIGHT);
    localparam logic [LOG_MAX_WEIGHT:0]   ONE_OP = (LOG_MAX_WEIGHT+1)'(1);

    typedef enum logic [1:0] {IDLE, FETCH, EMIT, FIN} state_t;

    state_t                    state;
    logic [LOG_MAX_WEIGHT-1:0] r, d, idx;
    logic [LFSR_WIDTH-1:0]     lfsr, lfsr_nxt;
    logic [M-1:0]              dl_raw, dl_mod, dl_q, loc_q;
    logic [LOG_MAX_WEIGHT:0]   remain;
    logic                      sel_dummy, first, in_range;

    always_comb begin
        lfsr_nxt  = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
        dl_raw    = lfsr_nxt[M-1:0];
        dl_mod    = (dl_raw >= N_M) ? dl_raw - N_M : dl_raw;
        sel_dummy = (d != '0) && ((r == '0) || lfsr_nxt[LFSR_WIDTH-1]);
        remain    = {1'b0, r} + {1'b0, d};
        in_range  = (weight != '0) && (weight <= MAXW);
    end

    // RAM data arrives in the first EMIT cycle; afterwards the captured copy keeps out_loc stable
    assign out_loc = out_dummy ? dl_q : (first ? loc_in : loc_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            lfsr      <= LFSR_SEED;
            r         <= '0;
            d         <= '0;
            idx       <= '0;
            loc_addr  <= '0;
            dl_q      <= '0;
            loc_q     <= '0;
            first     <= 1'b0;
            out_valid <= 1'b0;
            out_dummy <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (seed_load)
                        lfsr <= (seed_in == '0) ? LFSR_SEED : seed_in;
                    if (start) begin
                        r        <= weight;
                        d        <= dummy_en ? MAXW - weight : '0;
                        idx      <= '0;
                        loc_addr <= '0;
                        if (in_range) begin
                            err   <= 1'b0;
                            busy  <= 1'b1;
                            state <= FETCH;
                        end else begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end
                end
                FETCH: begin
                    lfsr      <= lfsr_nxt;
                    out_dummy <= sel_dummy;
                    dl_q      <= dl_mod;
                    out_last  <= (remain == ONE_OP);
                    if (sel_dummy) begin
                        d <= d - 1'b1;
                    end else begin
                        r   <= r - 1'b1;
                        idx <= idx + 1'b1;
                    end
                    out_valid <= 1'b1;
                    first     <= 1'b1;
                    state     <= EMIT;
                end
                EMIT: begin
                    first <= 1'b0;
                    if (first) begin
                        loc_q <= loc_in;
                        if (!out_dummy && (loc_in >= N_M))
                            err <= 1'b1;
                    end
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (remain != '0) begin
                            loc_addr <= idx;
                            state    <= FETCH;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sparse_loc_scheduler.sv
// Scoreboard bench for sparse_loc_scheduler: directed runs push expected ops into a queue,
// a negedge monitor pops and compares every accepted op and checks stall stability.
module tb_sparse_loc_scheduler;
    localparam int MW = 75;
    localparam int NN = 17669;
    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct {
        logic [14:0] loc;
        logic        dummy;
        logic        last;
    } op_t;

    logic        clk = 1'b0;
    logic        rst, start, dummy_en, seed_load, out_ready;
    logic        out_valid, out_dummy, out_last, busy, done, err;
    logic [6:0]  weight, loc_addr;
    logic [15:0] seed_in;
    logic [14:0] loc_in, out_loc;
    logic [14:0] ram [0:127];

    sparse_loc_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .weight(weight), .dummy_en(dummy_en),
        .seed_load(seed_load), .seed_in(seed_in), .loc_addr(loc_addr), .loc_in(loc_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_loc(out_loc),
        .out_dummy(out_dummy), .out_last(out_last), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // synchronous location RAM: data valid one cycle after the address
    always @(posedge clk) loc_in <= ram[loc_addr];

    int   n_cmp = 0, n_bad = 0, pops = 0, done_cnt = 0;
    op_t  exp_q[$];
    op_t  hold, e;
    bit   hold_v = 0, toggle = 0;
    logic [15:0] m_lfsr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic model_run(input int w, input bit en);
        int  r, d, idx, x;
        op_t op;
        r = w; d = en ? MW - w : 0; idx = 0;
        while (r + d > 0) begin
            m_lfsr  = step(m_lfsr);
            op.last = (r + d == 1);
            if (d > 0 && (r == 0 || m_lfsr[15])) begin
                x = int'(m_lfsr[14:0]);
                if (x >= NN) x -= NN;
                op.loc = 15'(x); op.dummy = 1'b1; d--;
            end else begin
                op.loc = ram[idx]; op.dummy = 1'b0; idx++; r--;
            end
            exp_q.push_back(op);
        end
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready = toggle ? ~out_ready : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (out_valid) begin
                if (hold_v)
                    chk("stall_stable", {out_loc, out_dummy, out_last}, {hold.loc, hold.dummy, hold.last});
                if (out_dummy)
                    chk("dummy_below_n", 32'(out_loc < 15'(NN)), 1);
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_op: got loc %0d with no op expected", out_loc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("op_loc", out_loc, e.loc);
                        chk("op_dummy", out_dummy, e.dummy);
                        chk("op_last", out_last, e.last);
                    end
                    pops++;
                    hold_v = 0;
                end else begin
                    hold_v = 1;
                    hold.loc = out_loc; hold.dummy = out_dummy; hold.last = out_last;
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic run(input int w, input bit en, input bit sl, input logic [15:0] sd,
                       input bit tog, input int lat, input bit exp_err);
        int cyc;
        bit got, ok;
        ok = (w >= 1 && w <= MW);
        if (sl) m_lfsr = (sd == 16'h0) ? SEED : sd;
        if (ok) model_run(w, en);
        @(negedge clk);
        weight = 7'(w); dummy_en = en; seed_load = sl; seed_in = sd; start = 1'b1; toggle = tog;
        @(posedge clk); #1;
        start = 1'b0; seed_load = 1'b0;
        cyc = 0; got = 0;
        while (!got && cyc < 3000) begin
            @(negedge clk); cyc++;
            if (cyc == 1) chk("busy_after_start", busy, 32'(ok));
            if (done) got = 1;
        end
        chk("done_seen", 32'(got), 1);
        if (lat >= 0) chk("done_latency", cyc, lat);
        chk("ops_left", exp_q.size(), 0);
        chk("err_flag", err, 32'(exp_err));
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("busy_dropped", busy, 0);
        toggle = 0;
    endtask

    initial begin
        int dc, guard, p0;
        rst = 1'b0; start = 1'b0; weight = '0; dummy_en = 1'b0;
        seed_load = 1'b0; seed_in = '0;
        for (int i = 0; i < 128; i++) ram[i] = 15'(i * 100);
        #12;
        chk("rst_valid", out_valid, 0); chk("rst_loc", out_loc, 0);
        chk("rst_dummy", out_dummy, 0); chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
        chk("rst_err", err, 0);         chk("rst_addr", loc_addr, 0);
        m_lfsr = SEED;
        @(negedge clk); rst = 1'b1;

        run(66, 0, 0, 16'h0, 0, 133, 0);          // real ops only
        run(66, 1, 1, SEED, 0, 151, 0);           // padded to 75
        run(66, 1, 1, SEED, 0, 151, 0);           // same seed, same sequence
        run(66, 1, 1, SEED, 1, -1, 0);            // ready toggling
        run(0, 0, 0, 16'h0, 0, 1, 1);             // out of range low
        run(76, 1, 0, 16'h0, 0, 1, 1);            // out of range high
        run(3, 0, 0, 16'h0, 0, 7, 0);             // valid start clears err

        // abort by reset during op 30 of a padded run
        m_lfsr = SEED;
        model_run(66, 1);
        @(negedge clk);
        weight = 7'd66; dummy_en = 1'b1; seed_load = 1'b1; seed_in = SEED; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; seed_load = 1'b0;
        p0 = pops; guard = 0;
        while (pops < p0 + 30 && guard < 500) begin @(negedge clk); guard++; end
        chk("reached_op30", 32'(pops >= p0 + 30), 1);
        #2 rst = 1'b0; dc = done_cnt;
        #1;
        chk("abort_valid", out_valid, 0); chk("abort_busy", busy, 0);
        chk("abort_loc", out_loc, 0);     chk("abort_dummy", out_dummy, 0);
        chk("abort_last", out_last, 0);   chk("abort_addr", loc_addr, 0);
        exp_q.delete(); hold_v = 0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_done", done_cnt, dc);
        m_lfsr = SEED;
        run(66, 1, 0, 16'h0, 0, 151, 0);          // fresh run from reset seed

        run(75, 1, 0, 16'h0, 0, 151, 0);          // full weight: no dummies
        run(66, 1, 1, 16'h0, 0, 151, 0);          // zero seed maps to reset seed
        ram[5] = 15'd17700;
        run(10, 0, 0, 16'h0, 0, 21, 1);           // bad location still emitted
        ram[5] = 15'd500;
        run(10, 1, 0, 16'h0, 0, 151, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sparse_loc_scheduler.md
Name: sparse_loc_scheduler

Overview:
Front-end sequencer for the sparse-dense polynomial multiplier. It reads the WEIGHT real sparse locations from the location RAM. When dummy_en is set, it pads the stream to exactly MAX_WEIGHT operations by interleaving dummy locations at LFSR-chosen slots, so that multiplier timing does not depend on the true weight. Operations are emitted one per handshake to the downstream shift-accumulate core, which discards the result of dummy ops.

Parameters:
MAX_WEIGHT, 75, padded operation count; upper bound on weight
N, 17669, polynomial length; every emitted location is < N
M, 15, location width; 2**M < 2*N required
LOG_MAX_WEIGHT, 7, CLOG2(MAX_WEIGHT+1)
LFSR_WIDTH, 16, LFSR width; must be >= M+1
LFSR_SEED, 16'hACE1, reset seed; also substituted whenever a zero seed is loaded

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; ignored unless in IDLE
weight  in  LOG_MAX_WEIGHT  real location count; sampled on start
dummy_en  in  1  pad to MAX_WEIGHT; sampled on start
seed_load  in  1  load seed_in into LFSR; honoured only in IDLE
seed_in  in  LFSR_WIDTH  new LFSR seed
loc_addr  out  LOG_MAX_WEIGHT  location RAM read address
loc_in  in  M  location RAM data; valid 1 cycle after loc_addr
out_valid  out  1  op available
out_ready  in  1  downstream accepts op
out_loc  out  M  location of current op
out_dummy  out  1  op is a dummy
out_last  out  1  op is the final op of the run
busy  out  1  high from the start-accept cycle until done
done  out  1  one-cycle pulse after the last op is accepted
err  out  1  sticky error flag; cleared on the next accepted start

Behaviour:
- Reset (rst=0, asynchronous) puts all outputs to 0, state to IDLE and the LFSR to LFSR_SEED.
- Counters: r = real locations remaining, d = dummies remaining, idx = next RAM address.
- On start: r=weight, d=dummy_en ? MAX_WEIGHT-weight : 0, idx=0, err=0.
- States: IDLE, FETCH, EMIT, FIN.
- IDLE -> FETCH on start when 1 <= weight <= MAX_WEIGHT.
- Weight out of range (weight==0 or weight>MAX_WEIGHT): IDLE -> FIN with err=1 and no ops emitted.
- FETCH (exactly 1 cycle, for both real and dummy ops; this keeps timing uniform):
  - loc_addr = idx, held even for dummy ops.
  - The LFSR advances one step (Galois, x^16+x^14+x^13+x^11+1).
  - Selection: sel_dummy = (d>0) && (r==0 || lfsr[LFSR_WIDTH-1]).
- FETCH -> EMIT. In the EMIT entry cycle:
  - out_loc = sel_dummy ? dl : loc_in, where dl = lfsr[M-1:0], minus N if >= N (single conditional subtract).
  - out_dummy = sel_dummy.
  - Decrement d or r accordingly; idx increments only on real ops.
  - out_last = (r+d == 1) before the decrement.
- EMIT:
  - out_valid is held high with out_loc, out_dummy and out_last stable until out_ready.
  - On acceptance: out_valid drops; go to FETCH if ops remain, else FIN.
  - Throughput: one op per 2 cycles when out_ready is held high.
- FIN: done=1 for one cycle, busy drops in the same cycle, then IDLE.
- Real loc_in >= N: sets err; the op is still emitted with out_loc = loc_in.
- Total ops per run = dummy_en ? MAX_WEIGHT : weight. Exactly weight ops have out_dummy=0, and they appear in RAM address order.
- start while busy: ignored. seed_load while busy: ignored.
- seed_load together with start in IDLE: seed is loaded first, and the run uses the new seed.
- Reset mid-run: aborts immediately with all outputs 0. No done pulse.

Test Plan:
1. rst low, then high; weight=66, dummy_en=0, out_ready=1, RAM[i]=i*100 -> 66 ops, out_loc=0,100,...,6500, all out_dummy=0, out_last on op 66, done pulse, 132-cycle FETCH/EMIT span.
2. weight=66, dummy_en=1, seed=16'hACE1 -> 75 ops: 9 with out_dummy=1, each dummy out_loc<17669; the 66 real ops keep order; done after 150 cycles; rerunning with the same seed reproduces the identical dummy positions and values.
3. Case 2 with out_ready toggling 1/0 every cycle -> same op sequence, each op held stable while stalled, no op lost or duplicated.
4. weight=0 and, separately, weight=76 -> no out_valid, err=1, done pulse within 2 cycles; next valid start clears err.
5. Pulse rst low during op 30 of case 2 -> outputs 0 immediately, no done; a fresh start then produces the full 75-op sequence from the reset seed.
6. weight=75, dummy_en=1 -> zero dummies; seed_in=0 loaded -> LFSR takes 16'hACE1; a RAM entry 17700 -> err=1, op still emitted.
